exc_sequencer: RTL and testbench

EXC_SEQUENCER -- requirements
Module: exc_sequencer

---
 rtl/exc_sequencer.sv | 173 +++++++++++++++++
 tb/tb_exc_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// exc_sequencer: sequences a precise exception or ERET taken at the memory stage.
// The request is captured in IDLE. The sequencer waits in DRAIN until the data bus
// is idle. In COMMIT it flushes the pipeline and writes CP0 for one cycle. In
// REDIRECT it offers the new fetch PC until fetch accepts it. The whole pipeline is
// stalled from the capture cycle until the redirect is accepted.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   exc_flag        exception/ERET pending (sampled only in IDLE)
//   exc_type        ExcCode of the request (0x1E = ERET)
//   exc_pc          PC of the faulting instruction
//   exc_baddr       faulting address
//   exc_bd          faulting instruction is in a delay slot
//   cp0_epc         current EPC (ERET return target)
//   status_bev      Status.BEV (selects the boot vector)
//   bus_busy        data-memory transaction outstanding
//   redirect_ready  fetch accepts the redirect
//   stall_all       freeze the whole pipeline
//   flush           kill all in-flight instructions (COMMIT only)
//   redirect_valid  redirect_pc offer
//   redirect_pc     new fetch PC
//   cp0_exc_we      write EPC/ExcCode/BD and set EXL
//   cp0_epc_o       EPC write data
//   cp0_exccode     Cause.ExcCode write data
//   cp0_bd          Cause.BD write data
//   cp0_badv_we     BadVAddr write enable
//   cp0_badv_o      BadVAddr write data
//   cp0_eret        clear Status.EXL
module exc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_flag,
  input  logic [4:0]  exc_type,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_baddr,
  input  logic        exc_bd,
  input  logic [31:0] cp0_epc,
  input  logic        status_bev,
  input  logic        bus_busy,
  input  logic        redirect_ready,
  output logic        stall_all,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cp0_exc_we,
  output logic [31:0] cp0_epc_o,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic        cp0_badv_we,
  output logic [31:0] cp0_badv_o,
  output logic        cp0_eret
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

  localparam logic [4:0]  CODE_ERET = 5'h1E;
  localparam logic [4:0]  CODE_ADEL = 5'h04;
  localparam logic [4:0]  CODE_ADES = 5'h05;
  localparam logic [31:0] VEC_BEV1  = 32'hBFC0_0380;
  localparam logic [31:0] VEC_BEV0  = 32'h8000_0180;

  state_t      state_q, state_d;
  logic [4:0]  type_q, type_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] baddr_q, baddr_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] rpc_q, rpc_d;

  // A delay-slot fault restarts at the branch, one word earlier (modular).
  function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  function automatic logic [31:0] target_pc(input logic [4:0] code,
                                            input logic [31:0] epc,
                                            input logic bev);
    if (code == CODE_ERET) return epc;
    return bev ? VEC_BEV1 : VEC_BEV0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q  <= '0;
      pc_q    <= '0;
      baddr_q <= '0;
      bd_q    <= 1'b0;
      epc_q   <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      baddr_q <= baddr_d;
      bd_q    <= bd_d;
      epc_q   <= epc_d;
      rpc_q   <= rpc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    type_d         = type_q;
    pc_d           = pc_q;
    baddr_d        = baddr_q;
    bd_d           = bd_q;
    epc_d          = epc_q;
    rpc_d          = rpc_q;
    stall_all      = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    cp0_exc_we     = 1'b0;
    cp0_epc_o      = '0;
    cp0_exccode    = '0;
    cp0_bd         = 1'b0;
    cp0_badv_we    = 1'b0;
    cp0_badv_o     = '0;
    cp0_eret       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The capture cycle stalls combinationally so the faulting
        // instruction cannot advance past the memory stage.
        stall_all = exc_flag;
        if (exc_flag) begin
          type_d  = exc_type;
          pc_d    = exc_pc;
          baddr_d = exc_baddr;
          bd_d    = exc_bd;
          epc_d   = cp0_epc;
          state_d = bus_busy ? DRAIN : COMMIT;
        end
      end
      DRAIN: begin
        stall_all = 1'b1;
        if (!bus_busy) state_d = COMMIT;
      end
      COMMIT: begin
        stall_all = 1'b1;
        flush     = 1'b1;
        // CP0 strobes are held off in a reset cycle, so an interrupted
        // sequence never lands a CP0 write.
        if (type_q == CODE_ERET) begin
          cp0_eret = !rst;
        end else begin
          cp0_exc_we = !rst;
          if (!rst) begin
            cp0_epc_o   = restart_pc(pc_q, bd_q);
            cp0_exccode = type_q;
            cp0_bd      = bd_q;
          end
          if (!rst && (type_q == CODE_ADEL || type_q == CODE_ADES)) begin
            cp0_badv_we = 1'b1;
            cp0_badv_o  = baddr_q;
          end
        end
        // BEV is sampled here and frozen with the target for the whole offer.
        rpc_d   = target_pc(type_q, epc_q, status_bev);
        state_d = REDIRECT;
      end
      REDIRECT: begin
        stall_all      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = rpc_q;
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_sequencer.sv
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        rst, exc_flag, exc_bd, status_bev, bus_busy, redirect_ready;
  logic [4:0]  exc_type;
  logic [31:0] exc_pc, exc_baddr, cp0_epc;
  logic        stall_all, flush, redirect_valid, cp0_exc_we, cp0_bd, cp0_badv_we, cp0_eret;
  logic [31:0] redirect_pc, cp0_epc_o, cp0_badv_o;
  logic [4:0]  cp0_exccode;

  exc_sequencer dut (
    .clk(clk), .rst(rst), .exc_flag(exc_flag), .exc_type(exc_type), .exc_pc(exc_pc),
    .exc_baddr(exc_baddr), .exc_bd(exc_bd), .cp0_epc(cp0_epc), .status_bev(status_bev),
    .bus_busy(bus_busy), .redirect_ready(redirect_ready), .stall_all(stall_all),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cp0_exc_we(cp0_exc_we), .cp0_epc_o(cp0_epc_o), .cp0_exccode(cp0_exccode),
    .cp0_bd(cp0_bd), .cp0_badv_we(cp0_badv_we), .cp0_badv_o(cp0_badv_o),
    .cp0_eret(cp0_eret)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    end
  endtask

  // Reference model: one outstanding request record plus where it is in its life:
  // waiting for the bus, allowed to commit this cycle, or being offered to fetch.
  bit          chk_en = 1'b0;
  bit          m_pend = 1'b0, m_go = 1'b0, m_offer = 1'b0, m_bd = 1'b0;
  logic [4:0]  m_type = '0;
  logic [31:0] m_pc = '0, m_baddr = '0, m_epc = '0, m_rpc = '0;

  logic        e_stall, e_flush, e_rv, e_we, e_bd, e_badv, e_eret;
  logic [31:0] e_rpc, e_epc, e_badv_o;
  logic [4:0]  e_code;

  always @(negedge clk) begin
    if (chk_en) begin
      e_stall = 0; e_flush = 0; e_rv = 0; e_we = 0; e_bd = 0; e_badv = 0; e_eret = 0;
      e_rpc = 0; e_epc = 0; e_badv_o = 0; e_code = 0;
      if (m_offer) begin
        e_stall = 1; e_rv = 1; e_rpc = m_rpc;
      end else if (m_pend && m_go) begin
        e_stall = 1; e_flush = 1;
        if (m_type == 5'h1E) e_eret = !rst;
        else if (!rst) begin
          e_we   = 1;
          e_epc  = m_bd ? m_pc - 32'd4 : m_pc;
          e_code = m_type;
          e_bd   = m_bd;
          if (m_type == 5'h04 || m_type == 5'h05) begin
            e_badv = 1; e_badv_o = m_baddr;
          end
        end
      end else if (m_pend) begin
        e_stall = 1;
      end else begin
        e_stall = exc_flag;
      end

      chk("stall_all", stall_all, e_stall);
      chk("flush", flush, e_flush);
      chk("redirect_valid", redirect_valid, e_rv);
      chk("redirect_pc", redirect_pc, e_rpc);
      chk("cp0_exc_we", cp0_exc_we, e_we);
      chk("cp0_epc_o", cp0_epc_o, e_epc);
      chk("cp0_exccode", cp0_exccode, e_code);
      chk("cp0_bd", cp0_bd, e_bd);
      chk("cp0_badv_we", cp0_badv_we, e_badv);
      chk("cp0_badv_o", cp0_badv_o, e_badv_o);
      chk("cp0_eret", cp0_eret, e_eret);

      if (rst) begin
        m_pend = 0; m_go = 0; m_offer = 0;
        m_type = 0; m_pc = 0; m_baddr = 0; m_bd = 0; m_epc = 0; m_rpc = 0;
      end else if (m_offer) begin
        if (redirect_ready) m_offer = 0;
      end else if (m_pend && m_go) begin
        m_pend  = 0;
        m_offer = 1;
        m_rpc   = (m_type == 5'h1E) ? m_epc : (status_bev ? 32'hBFC0_0380 : 32'h8000_0180);
      end else if (m_pend) begin
        m_go = !bus_busy;
      end else if (exc_flag) begin
        m_pend = 1; m_go = !bus_busy;
        m_type = exc_type; m_pc = exc_pc; m_baddr = exc_baddr; m_bd = exc_bd; m_epc = cp0_epc;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic [4:0] t, input logic [31:0] pc, input logic [31:0] ba,
                       input logic bd, input logic [31:0] epc);
    exc_flag = 1; exc_type = t; exc_pc = pc; exc_baddr = ba; exc_bd = bd; cp0_epc = epc;
  endtask

  logic [4:0] codes [11] = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0A,
                             5'h0B, 5'h0C, 5'h0D, 5'h1E, 5'h00};

  initial begin
    rst = 1; exc_flag = 0; exc_type = 0; exc_pc = 0; exc_baddr = 0; exc_bd = 0;
    cp0_epc = 0; status_bev = 0; bus_busy = 0; redirect_ready = 0;
    cyc();
    chk_en = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("reset_stall", stall_all, 0);
    chk("reset_rv", redirect_valid, 0);
    chk("reset_rpc", redirect_pc, 0);
    chk("reset_we", cp0_exc_we, 0);
    chk("reset_flush", flush, 0);

    // Syscall, minimum latency
    cyc();
    redirect_ready = 1;
    raise(5'h08, 32'h8000_1000, 32'h0, 0, 32'h0);
    @(negedge clk); chk("sys_capture_stall", stall_all, 1);
    cyc(); exc_flag = 0;
    @(negedge clk);
    chk("sys_flush", flush, 1);
    chk("sys_we", cp0_exc_we, 1);
    chk("sys_epc", cp0_epc_o, 32'h8000_1000);
    chk("sys_code", cp0_exccode, 5'h08);
    chk("sys_badv_we", cp0_badv_we, 0);
    cyc();
    @(negedge clk);
    chk("sys_rv", redirect_valid, 1);
    chk("sys_rpc", redirect_pc, 32'h8000_0180);
    cyc();
    @(negedge clk); chk("sys_idle", stall_all, 0);
    cyc();

    // AdES in a delay slot
    raise(5'h05, 32'h8000_2004, 32'h0000_0003, 1, 32'h0);
    cyc(); exc_flag = 0;
    @(negedge clk);
    chk("ades_epc", cp0_epc_o, 32'h8000_2000);
    chk("ades_bd", cp0_bd, 1);
    chk("ades_badv_we", cp0_badv_we, 1);
    chk("ades_badv", cp0_badv_o, 32'h0000_0003);
    repeat (3) cyc();

    // EPC wraps below zero for a delay-slot fault at PC 0
    raise(5'h0A, 32'h0, 32'h0, 1, 32'h0);
    cyc(); exc_flag = 0;
    @(negedge clk);
    chk("wrap_epc", cp0_epc_o, 32'hFFFF_FFFC);
    chk("wrap_badv_we", cp0_badv_we, 0);
    repeat (3) cyc();

    // Drain: bus busy for the capture cycle and five more
    bus_busy = 1;
    raise(5'h0C, 32'h8000_3000, 32'h0, 0, 32'h0);
    cyc(); exc_flag = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drain_stall", stall_all, 1);
      chk("drain_flush", flush, 0);
      cyc();
    end
    bus_busy = 0;
    @(negedge clk); chk("drain_last_flush", flush, 0);
    cyc();
    @(negedge clk); chk("drain_commit_flush", flush, 1);
    repeat (3) cyc();

    // ERET with fetch stalling the redirect
    redirect_ready = 0;
    raise(5'h1E, 32'h0, 32'h0, 0, 32'h8000_0400);
    cyc(); exc_flag = 0;
    @(negedge clk);
    chk("eret_pulse", cp0_eret, 1);
    chk("eret_we", cp0_exc_we, 0);
    chk("eret_badv_we", cp0_badv_we, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("eret_rv", redirect_valid, 1);
      chk("eret_rpc", redirect_pc, 32'h8000_0400);
      chk("eret_no_repeat", cp0_eret, 0);
      cyc();
    end
    redirect_ready = 1;
    @(negedge clk); chk("eret_rv_accept", redirect_valid, 1);
    cyc();
    @(negedge clk); chk("eret_idle", stall_all, 0);
    cyc();

    // Reset in the middle of DRAIN
    bus_busy = 1;
    raise(5'h0C, 32'h8000_5000, 32'h0, 0, 32'h0);
    cyc(); exc_flag = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0; bus_busy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstdrain_stall", stall_all, 0);
      chk("rstdrain_flush", flush, 0);
      chk("rstdrain_we", cp0_exc_we, 0);
      cyc();
    end

    // BEV=1 interrupt; BEV dropped and a new request raised during REDIRECT
    status_bev = 1; redirect_ready = 0;
    raise(5'h00, 32'h8000_4000, 32'h0, 0, 32'h0);
    cyc(); exc_flag = 0;
    cyc();
    status_bev = 0;
    raise(5'h08, 32'h8000_6000, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("bev_rv", redirect_valid, 1);
    chk("bev_rpc", redirect_pc, 32'hBFC0_0380);
    cyc();
    redirect_ready = 1;
    cyc();
    exc_flag = 0;
    @(negedge clk); chk("bev_ignored_stall", stall_all, 0);
    cyc();
    @(negedge clk); chk("bev_ignored_flush", flush, 0);
    cyc();

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(63) == 0);
      exc_flag       = ($urandom_range(3) == 0);
      bus_busy       = $urandom_range(1);
      redirect_ready = $urandom_range(1);
      status_bev     = $urandom_range(1);
      exc_bd         = $urandom_range(1);
      exc_pc         = $urandom;
      exc_baddr      = $urandom;
      cp0_epc        = $urandom;
      exc_type       = codes[$urandom_range(10)];
      if ($urandom_range(10) == 0) exc_type = 5'($urandom);
      cyc();
    end

    rst = 0; exc_flag = 0; bus_busy = 0; redirect_ready = 1;
    repeat (5) cyc();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
